// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: datapath width, PC generator state encoding,
// default boot address and the branch-target alignment helper.
package msrv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] BOOT_ADDRESS_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_RUN  = 2'd0,
    PC_PEND = 2'd1,
    PC_HOLD = 2'd2
  } pc_state_e;

  // Jump/branch targets drop bit 0; bit 1 is kept and checked for misalignment.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
    return {t[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/msrv32_flush_counter.sv
// Wrong-path squash counter: reloads on redirect, counts down once per
// accepted fetch, saturates at zero. Flag is high while the count is non-zero.
module msrv32_flush_counter #(
  parameter logic [2:0] RELOAD = 3'd1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_in,
  input  logic dec_in,
  output logic flush_out
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_in) begin
      cnt_d = RELOAD;
    end else if (dec_in && (cnt_q != '0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign flush_out = (cnt_q != '0);

endmodule

// File: rtl/msrv32_pc_gen_stage.sv
// Fetch-side PC generator: fetch address and execute PC registers, pending
// redirect buffer for stalled branches, misaligned-target hold and trap redirect.
module msrv32_pc_gen_stage
  import msrv32_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDRESS = BOOT_ADDRESS_DEFAULT,
  parameter int unsigned     FLUSH_CYCLES = 1
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-1:0] target_in,
  input  logic            trap_taken_in,
  input  logic [XLEN-1:0] trap_address_in,
  input  logic            imem_ready_in,
  output logic [XLEN-1:0] i_addr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_4_out,
  output logic            flush_out,
  output logic            misaligned_instr_out
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] i_addr_q, i_addr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            misaligned_q, misaligned_d;

  logic            flush_w;
  logic            flush_load;
  logic            flush_dec;
  logic            branch_live;
  logic [XLEN-1:0] eff_target;
  logic            unused_trap_bits;

  assign eff_target       = align_target(target_in);
  assign branch_live      = branch_taken_in & ~flush_w;
  assign unused_trap_bits = ^trap_address_in[1:0];

  always_comb begin
    state_d       = state_q;
    i_addr_d      = i_addr_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    misaligned_d  = misaligned_q;
    flush_load    = 1'b0;
    flush_dec     = 1'b0;

    if (trap_taken_in) begin
      // Trap redirect overrides everything and does not wait for imem ready.
      i_addr_d      = {trap_address_in[XLEN-1:2], 2'b00};
      misaligned_d  = 1'b0;
      pend_target_d = '0;
      flush_load    = 1'b1;
      state_d       = PC_RUN;
    end else begin
      unique case (state_q)
        PC_RUN: begin
          if (branch_live && target_in[1]) begin
            misaligned_d = 1'b1;
            state_d      = PC_HOLD;
          end else if (branch_live && imem_ready_in) begin
            pc_d       = i_addr_q;
            i_addr_d   = eff_target;
            flush_load = 1'b1;
          end else if (branch_live) begin
            pend_target_d = eff_target;
            state_d       = PC_PEND;
          end else if (imem_ready_in) begin
            pc_d      = i_addr_q;
            i_addr_d  = i_addr_q + 32'd4;
            flush_dec = 1'b1;
          end
        end
        PC_PEND: begin
          if (imem_ready_in) begin
            pc_d          = i_addr_q;
            i_addr_d      = pend_target_q;
            pend_target_d = '0;
            flush_load    = 1'b1;
            state_d       = PC_RUN;
          end
        end
        PC_HOLD: begin
          state_d = PC_HOLD;
        end
        default: begin
          state_d = PC_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q       <= PC_RUN;
      i_addr_q      <= BOOT_ADDRESS;
      pc_q          <= BOOT_ADDRESS;
      pend_target_q <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_addr_q      <= i_addr_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      misaligned_q  <= misaligned_d;
    end
  end

  msrv32_flush_counter #(
    .RELOAD(3'(FLUSH_CYCLES))
  ) u_flush_counter (
    .clk      (ms_riscv32_mp_clk_in),
    .rst_n    (ms_riscv32_mp_rst_in),
    .load_in  (flush_load),
    .dec_in   (flush_dec),
    .flush_out(flush_w)
  );

  assign i_addr_out           = i_addr_q;
  assign pc_out               = pc_q;
  assign pc_plus_4_out        = pc_q + 32'd4;
  assign flush_out            = flush_w;
  assign misaligned_instr_out = misaligned_q;

endmodule

// File: tb/tb_msrv32_pc_gen_stage.sv
// Directed bench for msrv32_pc_gen_stage: a vector table walks the main
// fetch/redirect/stall/trap paths, followed by reset-in-PEND/HOLD sequences.
module tb_msrv32_pc_gen_stage;

  logic        clk;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] target;
  logic        trap_taken;
  logic [31:0] trap_address;
  logic        imem_ready;
  logic [31:0] i_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        flush;
  logic        misaligned;

  int unsigned n_compared;
  int unsigned n_mismatched;

  msrv32_pc_gen_stage #(
    .BOOT_ADDRESS(32'h0000_0000),
    .FLUSH_CYCLES(1)
  ) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst_n),
    .branch_taken_in     (branch_taken),
    .target_in           (target),
    .trap_taken_in       (trap_taken),
    .trap_address_in     (trap_address),
    .imem_ready_in       (imem_ready),
    .i_addr_out          (i_addr),
    .pc_out              (pc),
    .pc_plus_4_out       (pc_plus_4),
    .flush_out           (flush),
    .misaligned_instr_out(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        trap;
    logic [31:0] trap_addr;
    logic        taken;
    logic [31:0] tgt;
    logic        ready;
    logic [31:0] exp_iaddr;
    logic [31:0] exp_pc;
    logic        exp_flush;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic tr, input logic [31:0] ta, input logic tk,
                              input logic [31:0] tg, input logic rdy,
                              input logic [31:0] ei, input logic [31:0] ep,
                              input logic ef, input logic em);
    vec_t v;
    v.trap = tr; v.trap_addr = ta; v.taken = tk; v.tgt = tg; v.ready = rdy;
    v.exp_iaddr = ei; v.exp_pc = ep; v.exp_flush = ef; v.exp_mis = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                           input logic ef, input logic em);
    logic [31:0] ep4;
    ep4 = ep + 32'd4;
    check({tag, " i_addr"}, i_addr, ei);
    check({tag, " pc"}, pc, ep);
    check({tag, " pc_plus_4"}, pc_plus_4, ep4);
    check({tag, " flush"}, {31'd0, flush}, {31'd0, ef});
    check({tag, " misaligned"}, {31'd0, misaligned}, {31'd0, em});
  endtask

  task automatic drive(input logic tr, input logic [31:0] ta, input logic tk,
                       input logic [31:0] tg, input logic rdy);
    trap_taken   = tr;
    trap_address = ta;
    branch_taken = tk;
    target       = tg;
    imem_ready   = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    //           trap  trap_addr     tk  target        rdy  i_addr        pc            fl  mis
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 32'h0000_0004, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 32'h0000_0008, 32'h0000_0004, 0, 0));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 32'h0000_000C, 32'h0000_0008, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 32'h100,      1, 32'h0000_0100, 32'h0000_000C, 1, 0));
    vecs.push_back(mk(0, 32'h0,        1, 32'h500,      1, 32'h0000_0104, 32'h0000_0100, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 32'h200,      0, 32'h0000_0104, 32'h0000_0100, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 32'h300,      0, 32'h0000_0104, 32'h0000_0100, 0, 0));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0, 32'h0000_0104, 32'h0000_0100, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 32'h300,      1, 32'h0000_0200, 32'h0000_0104, 1, 0));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 32'h0000_0204, 32'h0000_0200, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 32'h102,      1, 32'h0000_0204, 32'h0000_0200, 0, 1));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 32'h0000_0204, 32'h0000_0200, 0, 1));
    vecs.push_back(mk(0, 32'h0,        1, 32'h400,      1, 32'h0000_0204, 32'h0000_0200, 0, 1));
    vecs.push_back(mk(1, 32'h1C3,      0, 32'h0,        0, 32'h0000_01C0, 32'h0000_0200, 1, 0));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 32'h0000_01C4, 32'h0000_01C0, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 32'h105,      1, 32'h0000_0104, 32'h0000_01C4, 1, 0));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 32'h0000_0108, 32'h0000_0104, 0, 0));
    vecs.push_back(mk(1, 32'hFFFF_FFFE, 1, 32'h700,     1, 32'hFFFF_FFFC, 32'h0000_0104, 1, 0));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 32'h0000_0000, 32'hFFFF_FFFC, 0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 32'h600,      0, 32'h0000_0000, 32'hFFFF_FFFC, 0, 0));
    vecs.push_back(mk(1, 32'h80,       0, 32'h0,        0, 32'h0000_0080, 32'hFFFF_FFFC, 1, 0));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 32'h0000_0084, 32'h0000_0080, 0, 0));
    vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1, 32'h0000_0088, 32'h0000_0084, 0, 0));

    drive(0, '0, 0, '0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].trap, vecs[i].trap_addr, vecs[i].taken, vecs[i].tgt, vecs[i].ready);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_iaddr, vecs[i].exp_pc,
                vecs[i].exp_flush, vecs[i].exp_mis);
    end

    // Reset while a stalled redirect to 0x200 is pending.
    drive(0, '0, 1, 32'h200, 0);
    step();
    check_all("pend_entry", 32'h88, 32'h84, 1'b0, 1'b0);
    drive(0, '0, 0, '0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst_pend", 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive(0, '0, 0, '0, 1);
      step();
      check_all($sformatf("post_rst%0d", k), 32'(4 * k), 32'(4 * (k - 1)), 1'b0, 1'b0);
    end

    // Reset while frozen on a misaligned target.
    drive(0, '0, 1, 32'h102, 1);
    step();
    check_all("hold_entry", 32'hC, 32'h8, 1'b0, 1'b1);
    drive(0, '0, 0, '0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst_hold", 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_all("post_rst_hold", 32'h4, 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
